// File: rtl/sc_io_pkg.sv
// Shared constants for the single-cycle computer I/O responder: address map,
// seven-segment glyphs, converter state encoding and small helper functions.
package sc_io_pkg;

  localparam logic [7:0] IO_OUT0 = 8'h80;
  localparam logic [7:0] IO_OUT1 = 8'h84;
  localparam logic [7:0] IO_LED  = 8'h88;
  localparam logic [7:0] IO_IN0  = 8'hC0;
  localparam logic [7:0] IO_IN1  = 8'hC4;
  localparam logic [7:0] IO_STAT = 8'hC8;

  // Active-low glyphs, bit0 = segment a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] CVT_IDLE  = 2'd0;
  localparam logic [1:0] CVT_LOAD  = 2'd1;
  localparam logic [1:0] CVT_SHIFT = 2'd2;
  localparam logic [1:0] CVT_DONE  = 2'd3;

  typedef struct packed {
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] one;
  } bcd3_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: {bcd[11:0], bin[7:0]} add-3 on digits >= 5, then shift left
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    for (int i = 0; i < 3; i++) begin
      t[8+4*i +: 4] = (t[8+4*i +: 4] >= 4'd5) ? t[8+4*i +: 4] + 4'd3 : t[8+4*i +: 4];
    end
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/sc_io_unit_if.sv
// CPU data-bus view of the I/O window: address, store data/strobe and load data.
interface sc_io_unit_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        wmem;
  logic [31:0] io_read_data;

  modport master (output addr, output datain, output wmem, input io_read_data);
  modport slave  (input addr, input datain, input wmem, output io_read_data);
endinterface

// File: rtl/sc_bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one shift per cycle).
// A start while busy aborts the running conversion and restarts from LOAD.
module sc_bin2bcd8
  import sc_io_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [7:0]  value_i,
  output logic        busy_o,
  output logic        done_o,
  output bcd3_t       bcd_o
);

  logic [1:0]  state_q, state_d;
  logic [7:0]  val_q, val_d;
  logic [19:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;

  // Next-state logic; start overrides every state so stale results are dropped
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      state_d = CVT_LOAD;
      val_d   = value_i;
    end else begin
      case (state_q)
        CVT_IDLE: state_d = CVT_IDLE;
        CVT_LOAD: begin
          sr_d    = {12'd0, val_q};
          cnt_d   = 3'd7;
          state_d = CVT_SHIFT;
        end
        CVT_SHIFT: begin
          sr_d  = dabble_step(sr_q);
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            state_d = CVT_DONE;
          end else begin
            state_d = CVT_SHIFT;
          end
        end
        CVT_DONE: state_d = CVT_IDLE;
        default:  state_d = CVT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= CVT_IDLE;
      val_q   <= 8'd0;
      sr_q    <= 20'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != CVT_IDLE);
  assign done_o = (state_q == CVT_DONE) && !start_i;
  assign bcd_o  = sr_q[19:8];

endmodule

// File: rtl/sc_io_unit.sv
// Memory-mapped I/O responder: output/LED registers, debounced inputs with
// sticky change status, and two BCD-driven seven-segment display triplets.
module sc_io_unit
  import sc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               resetn,
  sc_io_unit_if.slave        bus,
  input  logic [31:0]        in_port0,
  input  logic [31:0]        in_port1,
  output logic [31:0]        out_port0,
  output logic [31:0]        out_port1,
  output logic               led0,
  output logic               led1,
  output logic               led2,
  output logic               led3,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3,
  output logic [6:0]         hex4,
  output logic [6:0]         hex5
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [7:0]       word_s;
  logic             wr_out0_s, wr_out1_s, wr_led_s, wr_stat_s;
  logic [31:0]      out0_q, out1_q;
  logic [3:0]       led_q;
  logic [1:0]       status_q, status_d, clr_s, chg_s;
  logic [1:0][31:0] raw_s, deb_s;
  logic [2:0][6:0]  hexa_q, hexb_q;
  logic             busy0_s, busy1_s, done0_s, done1_s;
  bcd3_t            bcd0_s, bcd1_s;
  logic [31:0]      rd_s;
  logic             unused_s;

  // Word-aligned decode; every mapped address has bit 7 set, so the data-memory half never matches
  assign word_s    = {bus.addr[7:2], 2'b00};
  assign wr_out0_s = bus.wmem && (word_s == IO_OUT0);
  assign wr_out1_s = bus.wmem && (word_s == IO_OUT1);
  assign wr_led_s  = bus.wmem && (word_s == IO_LED);
  assign wr_stat_s = bus.wmem && (word_s == IO_STAT);

  assign raw_s[0] = in_port0;
  assign raw_s[1] = in_port1;

  for (genvar p = 0; p < 2; p++) begin : g_deb
    logic [31:0]   sync1_q, sync2_q, cand_q, deb_q;
    logic [CW-1:0] cnt_q;
    logic          accept_s;

    assign accept_s = (sync2_q == cand_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    assign chg_s[p] = accept_s && (cand_q != deb_q);
    assign deb_s[p] = deb_q;

    // Two-flop synchroniser feeding a candidate/stability counter
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        sync1_q <= 32'd0;
        sync2_q <= 32'd0;
        cand_q  <= 32'd0;
        deb_q   <= 32'd0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw_s[p];
        sync2_q <= sync1_q;
        if (sync2_q != cand_q) begin
          cand_q <= sync2_q;
          cnt_q  <= '0;
        end else if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
          cnt_q <= cnt_q + CW'(1);
          if (accept_s) begin
            deb_q <= cand_q;
          end
        end
      end
    end
  end

  // Sticky change flags: write-1-to-clear, a same-cycle set takes priority
  always_comb begin
    if (wr_stat_s) begin
      clr_s = bus.datain[1:0];
    end else begin
      clr_s = 2'b00;
    end
    status_d = (status_q & ~clr_s) | chg_s;
  end

  sc_bin2bcd8 u_cvt0 (
    .clock   (clock),
    .resetn  (resetn),
    .start_i (wr_out0_s),
    .value_i (bus.datain[7:0]),
    .busy_o  (busy0_s),
    .done_o  (done0_s),
    .bcd_o   (bcd0_s)
  );

  sc_bin2bcd8 u_cvt1 (
    .clock   (clock),
    .resetn  (resetn),
    .start_i (wr_out1_s),
    .value_i (bus.datain[7:0]),
    .busy_o  (busy1_s),
    .done_o  (done1_s),
    .bcd_o   (bcd1_s)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out0_q   <= 32'd0;
      out1_q   <= 32'd0;
      led_q    <= 4'd0;
      status_q <= 2'b00;
      hexa_q   <= {SEG_0, SEG_0, SEG_0};
      hexb_q   <= {SEG_0, SEG_0, SEG_0};
    end else begin
      status_q <= status_d;
      if (wr_out0_s) out0_q <= bus.datain;
      if (wr_out1_s) out1_q <= bus.datain;
      if (wr_led_s)  led_q  <= bus.datain[3:0];
      if (done0_s)   hexa_q <= {seg7(bcd0_s.hun), seg7(bcd0_s.ten), seg7(bcd0_s.one)};
      if (done1_s)   hexb_q <= {seg7(bcd1_s.hun), seg7(bcd1_s.ten), seg7(bcd1_s.one)};
    end
  end

  // Load data mux; anything outside the map reads as zero
  always_comb begin
    case (word_s)
      IO_OUT0: rd_s = out0_q;
      IO_OUT1: rd_s = out1_q;
      IO_LED:  rd_s = {28'd0, led_q};
      IO_IN0:  rd_s = deb_s[0];
      IO_IN1:  rd_s = deb_s[1];
      IO_STAT: rd_s = {30'd0, status_q};
      default: rd_s = 32'd0;
    endcase
  end

  assign bus.io_read_data = rd_s;
  assign out_port0 = out0_q;
  assign out_port1 = out1_q;
  assign {led3, led2, led1, led0} = led_q;
  assign {hex2, hex1, hex0} = hexa_q;
  assign {hex5, hex4, hex3} = hexb_q;

  assign unused_s = ^{bus.addr[31:8], bus.addr[1:0], busy0_s, busy1_s};

endmodule
